// File: rtl/serdes_word_aligner.sv
// Word aligner for a serial SERDES loopback: slips the word boundary one bit
// at a time until SYNC_WORD is seen LOCK_COUNT times in a row, then passes payload.
module serdes_word_aligner #(
    parameter int DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD = 8'h6A,
    parameter int LOCK_COUNT = 4,
    parameter int SLIP_WAIT = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  I_DAT,
    input  logic                  I_RETRAIN,
    output logic [DATA_WIDTH-1:0] O_DAT,
    output logic                  O_STB,
    output logic                  O_LOCKED,
    output logic [7:0]            O_SLIP_CNT
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
    localparam logic [2:0] WAIT_N = 3'(SLIP_WAIT);

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  hold_q, hold_d;
    logic [3:0]            mcnt_q, mcnt_d;
    logic [2:0]            wait_q, wait_d;
    logic [7:0]            slip_cnt_q, slip_cnt_d;
    logic                  stb_q, stb_d;
    logic                  locked_q, locked_d;
    logic                  capture;
    logic                  match;
    logic                  slip;

    always_comb begin
        sr_d       = {sr_q[DATA_WIDTH-2:0], I_DAT};
        capture    = (cnt_q == LAST);
        match      = (sr_d == SYNC_WORD);
        state_d    = state_q;
        dat_d      = dat_q;
        mcnt_d     = mcnt_q;
        wait_d     = wait_q;
        stb_d      = 1'b0;
        slip       = 1'b0;

        if (capture) begin
            dat_d = sr_d;
        end

        if (I_RETRAIN) begin
            state_d = HUNT;
            mcnt_d  = '0;
            wait_d  = '0;
        end else if (capture) begin
            stb_d = (state_q == LOCKED);
            if (wait_q != 3'd0) begin
                wait_d = wait_q - 3'd1;
            end else begin
                unique case (state_q)
                    HUNT: begin
                        if (match) begin
                            mcnt_d  = 4'd1;
                            state_d = (LOCK_N == 4'd1) ? LOCKED : CHECK;
                        end else begin
                            slip = 1'b1;
                        end
                    end
                    CHECK: begin
                        if (match) begin
                            mcnt_d = mcnt_q + 4'd1;
                            if (mcnt_q + 4'd1 == LOCK_N) begin
                                state_d = LOCKED;
                            end
                        end else begin
                            mcnt_d  = '0;
                            slip    = 1'b1;
                            state_d = HUNT;
                        end
                    end
                    LOCKED: begin
                        state_d = LOCKED;
                    end
                    default: begin
                        state_d = HUNT;
                    end
                endcase
            end
        end

        if (slip) begin
            wait_d = WAIT_N;
        end

        // A slip parks the counter at 0 for one extra bit, delaying the boundary.
        hold_d = 1'b0;
        if (hold_q) begin
            cnt_d = '0;
        end else if (capture) begin
            cnt_d  = '0;
            hold_d = slip;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        slip_cnt_d = slip_cnt_q;
        if (slip && slip_cnt_q != 8'hFF) begin
            slip_cnt_d = slip_cnt_q + 8'd1;
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= HUNT;
            sr_q       <= '0;
            dat_q      <= '0;
            cnt_q      <= '0;
            hold_q     <= 1'b0;
            mcnt_q     <= '0;
            wait_q     <= '0;
            slip_cnt_q <= '0;
            stb_q      <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            dat_q      <= dat_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            mcnt_q     <= mcnt_d;
            wait_q     <= wait_d;
            slip_cnt_q <= slip_cnt_d;
            stb_q      <= stb_d;
            locked_q   <= locked_d;
        end
    end

    assign O_DAT      = dat_q;
    assign O_STB      = stb_q;
    assign O_LOCKED   = locked_q;
    assign O_SLIP_CNT = slip_cnt_q;
endmodule

// File: tb/tb_serdes_word_aligner.sv
// Bench for serdes_word_aligner: cycle-level reference model of the
// alignment rules, directed scenario table, and randomized streams.
module tb_serdes_word_aligner;
    localparam int W = 8;
    localparam logic [7:0] SYNC = 8'h6A;
    localparam int LC = 4;
    localparam int SW = 2;

    logic         CLK = 1'b0;
    logic         RST;
    logic         I_DAT;
    logic         I_RETRAIN;
    logic [W-1:0] O_DAT;
    logic         O_STB;
    logic         O_LOCKED;
    logic [7:0]   O_SLIP_CNT;

    serdes_word_aligner #(
        .DATA_WIDTH(W),
        .SYNC_WORD(SYNC),
        .LOCK_COUNT(LC),
        .SLIP_WAIT(SW)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .I_DAT(I_DAT),
        .I_RETRAIN(I_RETRAIN),
        .O_DAT(O_DAT),
        .O_STB(O_STB),
        .O_LOCKED(O_LOCKED),
        .O_SLIP_CNT(O_SLIP_CNT)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    // Reference model: absolute bit index of the next word end, a run
    // length of consecutive sync matches, and an ignore count after slips.
    int           m_t;
    int           m_cap;
    int           m_run;
    int           m_ign;
    int           m_slips;
    bit           m_locked;
    logic [W-1:0] m_win;
    logic [W-1:0] e_dat;
    bit           e_stb;

    function automatic void model(input bit b, input bit r, input bit rst);
        bit slip;
        if (!rst) begin
            m_t = 0; m_cap = W - 1; m_run = 0; m_ign = 0; m_slips = 0;
            m_locked = 0; m_win = '0; e_dat = '0; e_stb = 0;
            return;
        end
        m_win = W'((m_win * 2 + b) % (1 << W));
        e_stb = 0;
        slip = 0;
        if (m_t == m_cap) begin
            e_dat = m_win;
            if (!r) begin
                if (m_locked) e_stb = 1;
                else if (m_ign > 0) m_ign--;
                else if (m_win == SYNC) begin
                    m_run++;
                    if (m_run >= LC) m_locked = 1;
                end else begin
                    m_run = 0;
                    slip = 1;
                    m_ign = SW;
                    if (m_slips < 255) m_slips++;
                end
            end
            m_cap = m_t + W + (slip ? 1 : 0);
        end
        if (r) begin
            m_locked = 0; m_run = 0; m_ign = 0;
        end
        m_t++;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit b, input bit r = 1'b0, input bit rst = 1'b1);
        int t0;
        RST = rst; I_DAT = b; I_RETRAIN = r;
        t0 = m_t;
        model(b, r, rst);
        @(posedge CLK);
        #1;
        chk($sformatf("cycle bit=%0d", t0),
            {O_DAT, O_STB, O_LOCKED, O_SLIP_CNT},
            {e_dat, e_stb, m_locked, m_slips[7:0]});
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0);
        chk("reset outputs", {O_DAT, O_STB, O_LOCKED, O_SLIP_CNT}, 0);
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) drive(w[i]);
    endtask

    function automatic bit sbit(input int i);
        logic [7:0] s;
        s = SYNC;
        return s[7 - (i % 8)];
    endfunction

    // Send sync bits from word position 'start'; n = bits until O_LOCKED.
    task automatic count_lock(input int start, output int n);
        n = -1;
        for (int i = 0; i < 80; i++) begin
            drive(sbit(start + i));
            if (O_LOCKED) begin
                n = i + 1;
                break;
            end
        end
    endtask

    typedef struct {
        int         garb;
        int         bad_word;
        int         nwords;
        int         slips;
        bit         lock;
        logic [7:0] dat;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int n;
        int stb_seen;
        logic [7:0] lf;
        logic [7:0] w;

        vecs[0] = '{0, -1, 6, 0, 1'b1, 8'h6A};
        vecs[1] = '{3, -1, 20, 3, 1'b1, 8'h6A};
        vecs[2] = '{0, 2, 40, 8, 1'b1, 8'h6A};
        vecs[3] = '{5, -1, 28, 5, 1'b1, 8'h6A};

        RST = 1'b0; I_DAT = 1'b0; I_RETRAIN = 1'b0;
        m_t = 0; m_cap = W - 1; m_run = 0; m_ign = 0; m_slips = 0;
        m_locked = 0; m_win = '0; e_dat = '0; e_stb = 0;

        for (int v = 0; v < 4; v++) begin
            do_reset();
            repeat (vecs[v].garb) drive(1'b1);
            for (int k = 0; k < vecs[v].nwords; k++)
                send_word(k == vecs[v].bad_word ? 8'h00 : SYNC);
            chk($sformatf("vec%0d slips", v), O_SLIP_CNT, vecs[v].slips);
            chk($sformatf("vec%0d locked", v), O_LOCKED, vecs[v].lock);
            chk($sformatf("vec%0d dat", v), O_DAT, vecs[v].dat);
        end

        // Aligned lock timing from reset.
        do_reset();
        count_lock(0, n);
        chk("lock after 32 bits", n, 32);
        send_word(SYNC);
        send_word(SYNC);

        // Retrain on a capture edge: word loads, strobe suppressed.
        for (int i = 0; i < 7; i++) drive(sbit(i));
        drive(sbit(7), 1'b1);
        chk("retrain unlock", O_LOCKED, 0);
        chk("retrain stb", O_STB, 0);
        chk("retrain dat", O_DAT, 8'h6A);
        count_lock(0, n);
        chk("relock after retrain", n, 32);
        chk("retrain slips", O_SLIP_CNT, 0);

        // Retrain mid-word.
        for (int i = 0; i < 4; i++) drive(sbit(i));
        drive(sbit(4), 1'b1);
        chk("midword retrain unlock", O_LOCKED, 0);
        count_lock(5, n);
        chk("relock after midword retrain", n, 27);

        // Reset while in CHECK.
        do_reset();
        send_word(SYNC);
        send_word(SYNC);
        drive(1'b1, 1'b1, 1'b0);
        chk("reset in check", {O_DAT, O_STB, O_LOCKED, O_SLIP_CNT}, 0);
        count_lock(0, n);
        chk("relock after reset", n, 32);

        // Locked payload pass-through.
        lf = 8'($urandom_range(1, 255));
        stb_seen = 0;
        for (int k = 0; k < 40; k++) begin
            lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
            send_word(lf);
            if (O_STB && O_DAT == lf) stb_seen++;
        end
        chk("payload strobes", stb_seen, 40);
        chk("payload locked", O_LOCKED, 1);
        chk("payload slips", O_SLIP_CNT, 0);

        // Slip counter saturation on a dead stream.
        do_reset();
        repeat (7000) drive(1'b0);
        chk("slip saturate", O_SLIP_CNT, 255);
        chk("dead unlocked", O_LOCKED, 0);

        // Random mix of sync/garbage words, bit shifts, retrain and reset.
        do_reset();
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 9) == 0) drive(1'($urandom));
            w = ($urandom_range(0, 1) == 0) ? SYNC : 8'($urandom);
            for (int i = 7; i >= 0; i--)
                drive(w[i], $urandom_range(0, 149) == 0,
                      $urandom_range(0, 499) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
